writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_arbiter
//  Description : Register-file writeback arbiter. Merges single-cycle ALU
//                results with buffered load results. It tracks loads that are
//                still outstanding in a scoreboard bitmap, and raises a
//                one-cycle stall to the ALU so that buffered loads cannot
//                starve.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDR_WIDTH-1:0]    alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDR_WIDTH-1:0]    mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     issue_valid,
    input  logic [ADDR_WIDTH-1:0]    issue_rd,
    output logic                     wen,
    output logic [ADDR_WIDTH-1:0]    writereg,
    output logic [DATA_WIDTH-1:0]    writedata,
    output logic [2**ADDR_WIDTH-1:0] pending,
    output logic                     stall_alu
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_nregs = 2**ADDR_WIDTH;
    localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);

    // Buffer storage and bookkeeping
    logic [ADDR_WIDTH-1:0] r_buf_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_buf_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    // Registered outputs and starvation tracking
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_writereg;
    logic [DATA_WIDTH-1:0] r_writedata;
    logic [c_nregs-1:0]    r_pending;
    logic                  r_stall;
    logic [c_stv_w-1:0]    r_starve;

    // Combinational decisions for the current edge
    logic                  w_ready;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_alu_win;
    logic                  w_pop;
    logic                  w_win;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_win_rd;
    logic [DATA_WIDTH-1:0] w_win_data;
    logic [c_stv_w-1:0]    w_starve_inc;
    logic [c_nregs-1:0]    w_one_hot_base;
    logic [c_nregs-1:0]    w_set_mask;
    logic [c_nregs-1:0]    w_clr_mask;

    // Ready depends only on registered occupancy, so a pop at the same edge
    // does not reopen a full buffer until the following cycle.
    assign w_ready   = (r_count < c_cnt_w'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = mem_valid && w_ready;
    assign mem_ready = w_ready;

    assign w_head_rd   = r_buf_rd[r_rd_ptr];
    assign w_head_data = r_buf_data[r_rd_ptr];

    // The ALU has no back-pressure. It wins whenever it presents a result,
    // even during a stall cycle, so that no ALU result is ever dropped. The
    // stall only asks upstream to leave a gap for the buffer.
    assign w_alu_win  = alu_valid;
    assign w_pop      = !alu_valid && !w_empty;
    assign w_win      = w_alu_win || w_pop;
    assign w_win_rd   = w_alu_win ? alu_rd   : w_head_rd;
    assign w_win_data = w_alu_win ? alu_data : w_head_data;

    assign w_starve_inc = r_starve + c_stv_w'(1);

    // Scoreboard masks: the set mask is applied after the clear mask, so a
    // set on the same bit at the same edge takes priority.
    assign w_one_hot_base = {{(c_nregs-1){1'b0}}, 1'b1};
    assign w_set_mask = (issue_valid && (issue_rd != '0)) ? (w_one_hot_base << issue_rd) : '0;
    assign w_clr_mask = (w_pop && (w_head_rd != '0)) ? (w_one_hot_base << w_head_rd) : '0;

    // Buffer payload storage: written on push only; no reset needed because
    // an entry is valid only through the pointers and the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_rd[r_wr_ptr]   <= mem_rd;
            r_buf_data[r_wr_ptr] <= mem_data;
        end
    end

    // Buffer pointers and occupancy. The pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    // Register-file write port. A winner targeting x0 is consumed but
    // suppresses the enable. On idle cycles the index and data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen       <= 1'b0;
            r_writereg  <= '0;
            r_writedata <= '0;
        end else begin
            r_wen <= w_win && (w_win_rd != '0);
            if (w_win) begin
                r_writereg  <= w_win_rd;
                r_writedata <= w_win_data;
            end
        end
    end

    // Starvation guard. The count rises on each ALU win over a non-empty
    // buffer. At the limit it raises a single-cycle stall and restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else if (w_alu_win && !w_empty) begin
            if (w_starve_inc == c_stv_w'(STARVE_LIMIT)) begin
                r_starve <= '0;
                r_stall  <= 1'b1;
            end else begin
                r_starve <= w_starve_inc;
                r_stall  <= 1'b0;
            end
        end else begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end
    end

    // Outstanding-load scoreboard: an issue sets a bit, a buffer pop clears it,
    // and ALU writes never touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign wen       = r_wen;
    assign writereg  = r_writereg;
    assign writedata = r_writedata;
    assign pending   = r_pending;
    assign stall_alu = r_stall;

endmodule
`default_nettype wire
